// File: rtl/uart_dbg_cmd_rx_pkg.sv
// Shared constants and state encodings for the debug command UART receiver.
// The CSUM parser state exists only when UART_DBG_CSUM_EN is defined.
package uart_dbg_cmd_rx_pkg;

  localparam logic [7:0] DBG_SYNC_BYTE   = 8'h5A;
  localparam logic [7:0] DBG_OP_WRITE_IM = 8'h01;
  localparam logic [7:0] DBG_OP_STEP     = 8'h02;
  localparam logic [7:0] DBG_OP_HALT     = 8'h03;
  localparam logic [7:0] DBG_OP_RUN      = 8'h04;

  typedef enum logic [2:0] {
    PS_WAIT_SYNC,
    PS_OP,
    PS_ADDR,
`ifdef UART_DBG_CSUM_EN
    PS_DATA,
    PS_CSUM
`else
    PS_DATA
`endif
  } dbg_pstate_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } dbg_rxstate_e;

endpackage

// File: rtl/uart_dbg_cmd_rx_rx_byte.sv
// Two-flop rx synchroniser plus 8N1 bit receiver.
// Emits one-cycle byte_valid / byte_err pulses per received byte.
module uart_rx_byte
  import uart_dbg_cmd_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       qclk,
  input  logic       resetn,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  logic          meta_q, rxs_q, rxp_q;
  dbg_rxstate_e  st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          brk_q, brk_d;
  logic          bv_q, bv_d;
  logic          be_q, be_d;

  always_ff @(posedge qclk) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
      rxp_q  <= 1'b1;
      st_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      brk_q  <= 1'b0;
      bv_q   <= 1'b0;
      be_q   <= 1'b0;
    end else begin
      meta_q <= rx;
      rxs_q  <= meta_q;
      rxp_q  <= rxs_q;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      brk_q  <= brk_d;
      bv_q   <= bv_d;
      be_q   <= be_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d  = sh_q;
    brk_d = brk_q;
    bv_d  = 1'b0;
    be_d  = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rxp_q && !rxs_q) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rxs_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          sh_d  = {rxs_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // A low stop bit parks here until the line recovers (break)
        if (brk_q) begin
          cnt_d = '0;
          if (rxs_q) begin
            brk_d = 1'b0;
            st_d  = RX_IDLE;
          end
        end else if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            bv_d = 1'b1;
            st_d = RX_IDLE;
          end else begin
            be_d  = 1'b1;
            brk_d = 1'b1;
          end
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = bv_q;
    byte_err   = be_q;
    byte_data  = sh_q;
  end

endmodule

// File: rtl/uart_dbg_cmd_rx.sv
// Debug command frame parser: 5A op addr d0..d3 [csum] -> cmd strobe.
// Define UART_DBG_CSUM_EN to require a trailing XOR checksum byte.
module uart_dbg_cmd_rx
  import uart_dbg_cmd_rx_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        qclk,
  input  logic        resetn,
  input  logic        rx,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [31:0] cmd_data,
  output logic        frame_err,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic       byte_valid, byte_err;
  logic [7:0] byte_data;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .qclk       (qclk),
    .resetn     (resetn),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err)
  );

  dbg_pstate_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  cop_q, cop_d;
  logic [7:0]  caddr_q, caddr_d;
  logic [31:0] cdata_q, cdata_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
`ifdef UART_DBG_CSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  always_ff @(posedge qclk) begin
    if (!resetn) begin
      state_q <= PS_WAIT_SYNC;
      idx_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      cop_q   <= '0;
      caddr_q <= '0;
      cdata_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_DBG_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      cop_q   <= cop_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_DBG_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cop_d   = cop_q;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    tmo_d   = (state_q == PS_WAIT_SYNC) ? '0 : tmo_q + 1'b1;
`ifdef UART_DBG_CSUM_EN
    csum_d  = csum_q;
`endif
    if (byte_err) begin
      ferr_d  = 1'b1;
      tmo_d   = '0;
      state_d = PS_WAIT_SYNC;
    end else if (byte_valid) begin
      // A byte arriving on the timeout cycle still counts
      tmo_d = '0;
      unique case (state_q)
        PS_WAIT_SYNC: begin
          if (byte_data == DBG_SYNC_BYTE) state_d = PS_OP;
        end
        PS_OP: begin
          op_d    = byte_data;
          state_d = PS_ADDR;
`ifdef UART_DBG_CSUM_EN
          csum_d  = byte_data;
`endif
        end
        PS_ADDR: begin
          addr_d  = byte_data;
          idx_d   = '0;
          state_d = PS_DATA;
`ifdef UART_DBG_CSUM_EN
          csum_d  = csum_q ^ byte_data;
`endif
        end
        PS_DATA: begin
          data_d = {byte_data, data_q[31:8]};
          idx_d  = idx_q + 2'd1;
`ifdef UART_DBG_CSUM_EN
          csum_d = csum_q ^ byte_data;
          if (idx_q == 2'd3) state_d = PS_CSUM;
`else
          if (idx_q == 2'd3) begin
            state_d = PS_WAIT_SYNC;
            valid_d = 1'b1;
            cop_d   = op_q;
            caddr_d = addr_q;
            cdata_d = data_d;
          end
`endif
        end
`ifdef UART_DBG_CSUM_EN
        PS_CSUM: begin
          state_d = PS_WAIT_SYNC;
          if (byte_data == csum_q) begin
            valid_d = 1'b1;
            cop_d   = op_q;
            caddr_d = addr_q;
            cdata_d = data_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
`endif
        default: state_d = PS_WAIT_SYNC;
      endcase
    end else if (state_q != PS_WAIT_SYNC && tmo_q == TMO_LAST) begin
      ferr_d  = 1'b1;
      tmo_d   = '0;
      state_d = PS_WAIT_SYNC;
    end
  end

  always_comb begin
    cmd_valid = valid_q;
    cmd_op    = cop_q;
    cmd_addr  = caddr_q;
    cmd_data  = cdata_q;
    frame_err = ferr_q;
    busy      = (state_q != PS_WAIT_SYNC);
  end

endmodule

// File: tb/tb_uart_dbg_cmd_rx.sv
// Randomised frame-level bench for uart_dbg_cmd_rx against a byte-queue model.
// Honours UART_DBG_CSUM_EN for frame length and checksum byte.
module tb_uart_dbg_cmd_rx;

  localparam int CF  = 1_600_000;
  localparam int BR  = 100_000;
  localparam int BIT = CF / BR;
  localparam int TMO = 3000;
`ifdef UART_DBG_CSUM_EN
  localparam int FLEN = 8;
`else
  localparam int FLEN = 7;
`endif

  logic        qclk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx = 1'b1;
  logic        cmd_valid, frame_err, busy;
  logic [7:0]  cmd_op, cmd_addr;
  logic [31:0] cmd_data;

  always #5 qclk = ~qclk;

  uart_dbg_cmd_rx #(
    .CLK_FREQ       (CF),
    .BAUD           (BR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .qclk      (qclk),
    .resetn    (resetn),
    .rx        (rx),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int act_v = 0;
  int act_e = 0;
  int exp_v = 0;
  int exp_e = 0;
  logic [7:0]  exp_op = '0;
  logic [7:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [7:0]  fb[$];

  always @(negedge qclk) begin
    if (cmd_valid) act_v++;
    if (frame_err) act_e++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 32'(act_v), 32'(exp_v));
    chk({tag, ".err"}, 32'(act_e), 32'(exp_e));
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, fb.size() != 0});
    chk({tag, ".op"}, {24'd0, cmd_op}, {24'd0, exp_op});
    chk({tag, ".addr"}, {24'd0, cmd_addr}, {24'd0, exp_addr});
    chk({tag, ".data"}, cmd_data, exp_data);
  endtask

  function automatic void model_byte(input logic [7:0] b);
    logic ok;
    if (fb.size() == 0) begin
      if (b == 8'h5A) fb.push_back(b);
      return;
    end
    fb.push_back(b);
    if (fb.size() < FLEN) return;
    ok = 1'b1;
`ifdef UART_DBG_CSUM_EN
    ok = (fb[7] == (fb[1] ^ fb[2] ^ fb[3] ^ fb[4] ^ fb[5] ^ fb[6]));
`endif
    if (ok) begin
      exp_v++;
      exp_op   = fb[1];
      exp_addr = fb[2];
      exp_data = {fb[6], fb[5], fb[4], fb[3]};
    end else begin
      exp_e++;
    end
    fb.delete();
  endfunction

  function automatic void model_err();
    exp_e++;
    fb.delete();
  endfunction

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge qclk);
  endtask

  task automatic put(input logic [7:0] b, input logic stop_ok);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    drive(stop_ok, BIT);
    if (!stop_ok) drive(1'b1, 2 * BIT);
    if (stop_ok) model_byte(b);
    else model_err();
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [31:0] d, input logic [7:0] cx);
    logic [7:0] bs[8];
    bs[0] = 8'h5A;
    bs[1] = op;
    bs[2] = addr;
    for (int i = 0; i < 4; i++) bs[3+i] = d[8*i +: 8];
    bs[7] = op ^ addr ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24] ^ cx;
    for (int i = 0; i < FLEN; i++) begin
      put(bs[i], 1'b1);
      drive(1'b1, $urandom_range(0, 20));
    end
  endtask

  task automatic long_gap();
    drive(1'b1, TMO + 500);
    if (fb.size() != 0) model_err();
  endtask

  initial begin
    repeat (3) @(negedge qclk);
    resetn = 1'b1;
    drive(1'b1, 2 * BIT);
    check_state("reset");

    send_frame(8'h01, 8'h10, 32'h12345678, 8'h00);
    check_state("frame1");

    put(8'h00, 1'b1);
    put(8'hFF, 1'b1);
    send_frame(8'h02, 8'h00, 32'h0, 8'h00);
    check_state("junk");

    drive(1'b0, 3);
    drive(1'b1, 40);
    check_state("glitch");

    put(8'h5A, 1'b1);
    put(8'h03, 1'b1);
    check_state("midframe");
    long_gap();
    check_state("timeout");
    send_frame(8'h04, 8'hA5, 32'hDEADBEEF, 8'h00);
    check_state("after_tmo");

    put(8'h5A, 1'b1);
    put(8'h04, 1'b1);
    put(8'h33, 1'b0);
    check_state("badstop");

`ifdef UART_DBG_CSUM_EN
    send_frame(8'h01, 8'h10, 32'h12345678, 8'h1A);
    check_state("csum_bad");
    send_frame(8'h01, 8'h10, 32'h12345678, 8'h00);
    check_state("csum_good");
`endif

    put(8'h5A, 1'b1);
    put(8'h01, 1'b1);
    resetn = 1'b0;
    repeat (2) @(negedge qclk);
    resetn = 1'b1;
    fb.delete();
    exp_op   = '0;
    exp_addr = '0;
    exp_data = '0;
    drive(1'b1, BIT);
    check_state("rst_mid");

    for (int k = 0; k < 24; k++) begin
      int sel;
      logic [7:0] b;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1: begin
          b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
          send_frame(8'($urandom), 8'($urandom), $urandom, b);
        end
        2: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h5A) b = 8'h5B;
          put(b, 1'b1);
        end
        3: begin
          drive(1'b0, int'($urandom_range(1, 5)));
          drive(1'b1, 40);
        end
        4: begin
          put(8'h5A, 1'b1);
          put(8'($urandom), 1'b1);
          put(8'($urandom), 1'b0);
        end
        default: begin
          put(8'h5A, 1'b1);
          for (int i = 0; i < int'($urandom_range(0, FLEN - 2)); i++)
            put(8'($urandom), 1'b1);
          long_gap();
        end
      endcase
      drive(1'b1, BIT);
      check_state($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
